// File: rtl/latch_bank_sched.sv
// Round-robin write scheduler for a reset-less gated-latch bank: setup, gate, hold (and optional CHECK) per write.
// Optional readback check of the written word is enabled with `define LATCH_VERIFY_EN.
module latch_bank_sched #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int GATE_CYCLES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Resetn,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [AW-1:0]          addr0,
  input  logic [AW-1:0]          addr1,
  input  logic [WIDTH-1:0]       data0,
  input  logic [WIDTH-1:0]       data1,
`ifdef LATCH_VERIFY_EN
  input  logic [WIDTH*DEPTH-1:0] lat_q,
`endif
  output logic                   ack0,
  output logic                   ack1,
  output logic [WIDTH-1:0]       lat_d,
  output logic [DEPTH-1:0]       lat_g,
  output logic                   busy,
  output logic                   grant_id,
  output logic                   err
);

  localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    GATE  = 3'd2,
    HOLD  = 3'd3
`ifdef LATCH_VERIFY_EN
    , CHECK = 3'd4
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             grant_q, grant_d;
  logic [DEPTH-1:0] lat_g_q, lat_g_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             win;
  logic             done;

  // Gate enables clear the instant Resetn falls, so an interrupted write cannot keep a latch open.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= 1'b0;
      lat_g_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      lat_g_q <= lat_g_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    grant_d = grant_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // ptr_q names the requester that wins a tie.
          win     = (req0 && req1) ? ptr_q : req1;
          grant_d = win;
          ptr_d   = ~win;
          addr_d  = win ? addr1 : addr0;
          data_d  = win ? data1 : data0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = GATE;
      end
      GATE: begin
        if (cnt_q == CW'(GATE_CYCLES - 1)) state_d = HOLD;
        else                               cnt_d   = cnt_q + CW'(1);
      end
`ifdef LATCH_VERIFY_EN
      HOLD:    state_d = CHECK;
      CHECK:   state_d = IDLE;
`else
      HOLD:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered values line up with the state they describe.
  always_comb begin
    lat_g_d = '0;
    if (state_d == GATE) lat_g_d[addr_d] = 1'b1;
`ifdef LATCH_VERIFY_EN
    done  = (state_d == CHECK);
    err_d = (state_d == CHECK) && (lat_q[addr_q*WIDTH +: WIDTH] != data_q);
`else
    done  = (state_d == HOLD);
    err_d = 1'b0;
`endif
    ack0_d = done && !grant_d;
    ack1_d = done &&  grant_d;
    busy_d = (state_d != IDLE);
  end

  assign lat_d    = data_q;
  assign lat_g    = lat_g_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;
  assign err      = err_q;

endmodule
